// File: rtl/addsub_pkg.sv
// addsub_pkg: shared op encodings and pipeline-depth helper for addsub_pipe.
package addsub_pkg;
    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_ADC = 2'b01;
    localparam logic [1:0] OP_SUB = 2'b10;
    localparam logic [1:0] OP_SBC = 2'b11;

    function automatic int nstage(input int width, input int slice);
        return width / slice;
    endfunction
endpackage

// File: rtl/addsub_slice.sv
// addsub_slice: combinational SLICE-bit add with carry out, carry into the top bit and zero detect.
module addsub_slice
    import addsub_pkg::*;
#(
    parameter int SLICE = 8
) (
    input  logic [SLICE-1:0] a,
    input  logic [SLICE-1:0] b,
    input  logic             ci,
    output logic [SLICE-1:0] s,
    output logic             co,
    output logic             c_msb_in,
    output logic             zero
);
    logic [SLICE:0] w_t;

    assign w_t      = {1'b0, a} + {1'b0, b} + {{SLICE{1'b0}}, ci};
    assign s        = w_t[SLICE-1:0];
    assign co       = w_t[SLICE];
    // Carry into the top bit is recovered from its sum bit and operands.
    assign c_msb_in = s[SLICE-1] ^ a[SLICE-1] ^ b[SLICE-1];
    assign zero     = ~|s;
endmodule

// File: rtl/addsub_pipe.sv
// addsub_pipe: WIDTH-bit adder/subtractor resolving one SLICE per pipeline stage,
// with C/V/Z flags and a globally stalled valid/ready pipeline.
module addsub_pipe
    import addsub_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SLICE = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       op,
    input  logic             cin,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_flag,
    output logic             v_flag,
    output logic             z_flag
);
    localparam int NSTAGE = nstage(WIDTH, SLICE);

    if (WIDTH % SLICE != 0) begin : g_bad_cfg
        $error("addsub_pipe: WIDTH must be a multiple of SLICE");
    end

    logic [WIDTH-1:0] w_b_eff;
    logic             w_ci0;
    logic             w_adv;

    assign w_b_eff  = op[1] ? ~b : b;
    assign w_ci0    = op[0] ? cin : op[1];
    assign w_adv    = !out_valid || out_ready;
    assign in_ready = w_adv;

    for (genvar k = 0; k < NSTAGE; k++) begin : g_st
        localparam int RW = WIDTH - (k + 1) * SLICE;
        logic [SLICE-1:0]         w_ai, w_bi, w_s;
        logic                     w_ci, w_vp, w_zp, w_co, w_cm, w_zero;
        logic [(k+1)*SLICE-1:0]   w_sn, r_s;
        logic                     r_vld, r_c, r_z;

        if (k == 0) begin : g_src
            assign w_ai = a[SLICE-1:0];
            assign w_bi = w_b_eff[SLICE-1:0];
            assign w_ci = w_ci0;
            assign w_vp = in_valid;
            assign w_zp = 1'b1;
            assign w_sn = w_s;
        end else begin : g_src
            assign w_ai = g_st[k-1].g_rem.r_a[SLICE-1:0];
            assign w_bi = g_st[k-1].g_rem.r_b[SLICE-1:0];
            assign w_ci = g_st[k-1].r_c;
            assign w_vp = g_st[k-1].r_vld;
            assign w_zp = g_st[k-1].r_z;
            assign w_sn = {w_s, g_st[k-1].r_s};
        end

        addsub_slice #(.SLICE(SLICE)) u_slice (
            .a        (w_ai),
            .b        (w_bi),
            .ci       (w_ci),
            .s        (w_s),
            .co       (w_co),
            .c_msb_in (w_cm),
            .zero     (w_zero)
        );

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_vld <= 1'b0;
                r_c   <= 1'b0;
                r_z   <= 1'b0;
                r_s   <= '0;
            end else if (w_adv) begin
                r_vld <= w_vp;
                r_c   <= w_co;
                r_z   <= w_zp & w_zero;
                r_s   <= w_sn;
            end
        end

        // Operand bits not yet resolved ride along with the beat.
        if (RW > 0) begin : g_rem
            logic [RW-1:0] w_ar, w_br, r_a, r_b;
            if (k == 0) begin : g_src
                assign w_ar = a[WIDTH-1:SLICE];
                assign w_br = w_b_eff[WIDTH-1:SLICE];
            end else begin : g_src
                assign w_ar = g_st[k-1].g_rem.r_a[RW+SLICE-1:SLICE];
                assign w_br = g_st[k-1].g_rem.r_b[RW+SLICE-1:SLICE];
            end
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_a <= '0;
                    r_b <= '0;
                end else if (w_adv) begin
                    r_a <= w_ar;
                    r_b <= w_br;
                end
            end
        end

        if (k == NSTAGE - 1) begin : g_last
            logic r_v;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) r_v <= 1'b0;
                else if (w_adv) r_v <= w_co ^ w_cm;
            end
        end
    end

    assign out_valid = g_st[NSTAGE-1].r_vld;
    assign sum       = g_st[NSTAGE-1].r_s;
    assign c_flag    = g_st[NSTAGE-1].r_c;
    assign z_flag    = g_st[NSTAGE-1].r_z;
    assign v_flag    = g_st[NSTAGE-1].g_last.r_v;
endmodule
